conv3x3_engine: RTL and testbench
=================================

CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 64, image side in pixels (power of 2, 4..128).
REQ-002 SHALL have parameter DW, default 20, pixel/weight/result width (signed fixed-point).
REQ-003 SHALL have parameter FRAC, default 16, fractional bits of DW values.
REQ-004 SHALL have parameter NK, default 2, kernel count (1..2); AW = 2*log2(IMG_W) is derived.
REQ-005 SHALL have port clk, in, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port reset, in, 1: reset is synchronous and active-high.
REQ-007 SHALL have port ready, in, 1: image memory ready; frame start request.
REQ-008 SHALL have port busy, out, 1: frame in progress.
REQ-009 SHALL have port iaddr, out, AW: image read address, row-major y*IMG_W+x.
REQ-010 SHALL have port idata, in, DW: image pixel, valid one cycle after iaddr.
REQ-011 SHALL have port wld, in, 1: weight load strobe.
REQ-012 SHALL have port wk, in, 1: kernel select for load.
REQ-013 SHALL have port widx, in, 4: tap 0..8 (row-major, 0 = top-left), 9 = bias; 10..15 ignored.
REQ-014 SHALL have port wdata, in, DW: weight/bias value.
REQ-015 SHALL have port relu_en, in, 1: clamp negative results to 0; sampled at frame start.
REQ-016 SHALL have port cwr, out, 1: result write enable.
REQ-017 SHALL have port caddr_wr, out, AW: result address y*IMG_W+x.
REQ-018 SHALL have port cdata_wr, out, DW: result data.
REQ-019 SHALL have port csel, out, 3: result memory select, 3'b001 kernel 0, 3'b010 kernel 1, 3'b000 idle.
REQ-020 SHALL have port done, out, 1: one-cycle end-of-frame pulse.

Function
REQ-021 SHALL implement FSM IDLE, FETCH, CALC, WRITE, DONE.
REQ-022 IDLE: busy=0; wld=1 SHALL write wdata to weight[wk][widx] next edge; wk>=NK ignored.
REQ-023 IDLE with ready=1 and wld=0 SHALL set busy=1, x=y=0, latch relu_en, enter FETCH; ready with wld=1 same cycle: load wins, start deferred.
REQ-024 wld and ready SHALL be ignored outside IDLE.
REQ-025 FETCH SHALL take exactly 9 cycles, tap t=0..8 at (x+t%3-1, y+t/3-1).
REQ-026 Out-of-image taps SHALL contribute 0, issue no new iaddr (iaddr holds), still take one cycle.
REQ-027 Accumulator per kernel SHALL be signed 2*DW+4 bits, initialised to bias<<FRAC; each tap adds pixel*weight (full signed product), all kernels in parallel.
REQ-028 CALC (1 cycle) SHALL add the last tap, then result = (acc + 2^(FRAC-1)) >>> FRAC, saturated to signed DW range, then ReLU if latched.
REQ-029 WRITE SHALL take NK cycles, kernel k on cycle k: cwr=1, csel=3'b001+k, caddr_wr=y*IMG_W+x, cdata_wr=result[k].
REQ-030 After WRITE: x<IMG_W-1 -> x+1, FETCH; x=IMG_W-1, y<IMG_W-1 -> x=0, y+1, FETCH; last pixel -> DONE.
REQ-031 Per-pixel latency SHALL be 10+NK cycles; frame = IMG_W^2*(10+NK) cycles from first FETCH to DONE.
REQ-032 DONE (1 cycle): done=1, busy=0, cwr=0, csel=0, then IDLE; weights retained across frames.
REQ-033 cwr SHALL be 0 and csel 3'b000 in every state except WRITE.

Reset
REQ-034 reset=1 at an edge SHALL force IDLE, busy=0, done=0, cwr=0, csel=0, iaddr=0, caddr_wr=0, cdata_wr=0, all weights/biases=0, accumulators=0, latched relu=0, including mid-frame; no further writes.

Verification
REQ-035 Reset: pulse reset in any state -> next cycle busy=0, cwr=0, csel=000, done=0, iaddr=0.
REQ-036 IMG_W=4, NK=1, idata=0x10000, all taps 0x08000, bias 0 -> corners 0x20000, edges 0x30000, interior 0x48000; 16 writes, done after 176 cycles.
REQ-037 Taps 0xF0000 (-1.0), idata 0x10000, relu_en=0 -> interior saturates 0x80000; relu_en=1 -> 0x00000.
REQ-038 Tap 4 = 0x00001, others 0, idata 0x08000 -> every result 0x00001 (round half up).
REQ-039 IMG_W=4, pixel (0,0): iaddr sequence for taps 4,5,7,8 = 0,1,4,5; taps 0-3,6 issue no new address; NK=2 writes csel 001 then 010 at caddr_wr 0.
REQ-040 reset during pixel 5 WRITE -> no further cwr; re-load weights, ready -> frame restarts at caddr_wr 0.

Source files
------------

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: walks an IMG_W x IMG_W image pixel by pixel, runs up to two
// kernels in parallel on each 3x3 neighbourhood and writes rounded, saturated results.
module conv3x3_engine #(
  parameter int IMG_W = 64,
  parameter int DW    = 20,
  parameter int FRAC  = 16,
  parameter int NK    = 2,
  localparam int LW   = $clog2(IMG_W),
  localparam int AW   = 2 * LW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  input  logic          wld,
  input  logic          wk,
  input  logic [3:0]    widx,
  input  logic [DW-1:0] wdata,
  input  logic          relu_en,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel,
  output logic          done,
  output logic [2:0]    dbg_state_o
);

  localparam int ACCW = 2 * DW + 4;
  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) <<< (FRAC - 1);
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [LW-1:0] XMAX = LW'(IMG_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CALC, S_WRITE, S_DONE} state_t;

  state_t                 state_q;
  logic [LW-1:0]          x_q, y_q, nx_d, ny_d;
  logic [3:0]             tap_q, ptap_q;
  logic                   inb_q, pv_q, relu_q, wcnt_q, last_wr_d;
  logic [DW-1:0]          w_q   [NK][10];
  logic signed [ACCW-1:0] acc_q [NK];
  logic signed [ACCW-1:0] acc_d [NK];
  logic signed [ACCW-1:0] bias_d[NK];
  logic [DW-1:0]          res_q [NK];
  logic [DW-1:0]          res_d [NK];

  assign dbg_state_o = state_q;

  // Tap t of pixel (px,py) sits at (px + t%3 - 1, py + t/3 - 1).
  function automatic logic tap_in(input logic [LW-1:0] px, input logic [LW-1:0] py,
                                  input logic [3:0] t);
    int tx, ty;
    tx = int'(px) + int'(t) % 3 - 1;
    ty = int'(py) + int'(t) / 3 - 1;
    return (tx >= 0) && (tx < IMG_W) && (ty >= 0) && (ty < IMG_W);
  endfunction

  function automatic logic [AW-1:0] tap_addr(input logic [LW-1:0] px, input logic [LW-1:0] py,
                                             input logic [3:0] t);
    int tx, ty;
    tx = int'(px) + int'(t) % 3 - 1;
    ty = int'(py) + int'(t) / 3 - 1;
    return {ty[LW-1:0], tx[LW-1:0]};
  endfunction

  always_comb begin
    nx_d      = x_q + 1'b1;
    ny_d      = y_q;
    last_wr_d = (int'(wcnt_q) == NK - 1);
    if (x_q == XMAX) begin
      nx_d = '0;
      ny_d = y_q + 1'b1;
    end
  end

  // The pixel read issued last cycle (pv_q/ptap_q) is folded into the accumulator now.
  always_comb begin
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] addend, sum, shf;
    prod   = '0;
    addend = '0;
    sum    = '0;
    shf    = '0;
    for (int k = 0; k < NK; k++) begin
      prod      = $signed(idata) * $signed(w_q[k][ptap_q]);
      addend    = '0;
      if (pv_q) addend = ACCW'(prod);
      acc_d[k]  = acc_q[k] + addend;
      bias_d[k] = ACCW'($signed(w_q[k][9])) <<< FRAC;
      sum       = acc_d[k] + HALF;
      shf       = sum >>> FRAC;
      if (shf > MAXV)      res_d[k] = DMAX;
      else if (shf < MINV) res_d[k] = DMIN;
      else                 res_d[k] = shf[DW-1:0];
      if (relu_q && res_d[k][DW-1]) res_d[k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      tap_q    <= '0;
      ptap_q   <= '0;
      inb_q    <= 1'b0;
      pv_q     <= 1'b0;
      relu_q   <= 1'b0;
      wcnt_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cwr      <= 1'b0;
      csel     <= '0;
      iaddr    <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      for (int k = 0; k < NK; k++) begin
        acc_q[k] <= '0;
        res_q[k] <= '0;
        for (int i = 0; i < 10; i++) w_q[k][i] <= '0;
      end
    end else begin
      cwr  <= 1'b0;
      csel <= '0;
      done <= 1'b0;
      pv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wld) begin
            if (int'(wk) < NK && widx <= 4'd9) w_q[wk][widx] <= wdata;
          end else if (ready) begin
            state_q <= S_FETCH;
            busy    <= 1'b1;
            relu_q  <= relu_en;
            x_q     <= '0;
            y_q     <= '0;
            tap_q   <= '0;
            inb_q   <= tap_in('0, '0, 4'd0);
            if (tap_in('0, '0, 4'd0)) iaddr <= tap_addr('0, '0, 4'd0);
            for (int k = 0; k < NK; k++) acc_q[k] <= bias_d[k];
          end
        end
        S_FETCH: begin
          pv_q   <= inb_q;
          ptap_q <= tap_q;
          for (int k = 0; k < NK; k++) acc_q[k] <= acc_d[k];
          if (tap_q == 4'd8) begin
            state_q <= S_CALC;
          end else begin
            tap_q <= tap_q + 4'd1;
            inb_q <= tap_in(x_q, y_q, tap_q + 4'd1);
            if (tap_in(x_q, y_q, tap_q + 4'd1)) iaddr <= tap_addr(x_q, y_q, tap_q + 4'd1);
          end
        end
        S_CALC: begin
          for (int k = 0; k < NK; k++) begin
            acc_q[k] <= acc_d[k];
            res_q[k] <= res_d[k];
          end
          state_q  <= S_WRITE;
          wcnt_q   <= 1'b0;
          cwr      <= 1'b1;
          csel     <= 3'b001;
          caddr_wr <= {y_q, x_q};
          cdata_wr <= res_d[0];
        end
        S_WRITE: begin
          if (!last_wr_d) begin
            wcnt_q   <= 1'b1;
            cwr      <= 1'b1;
            csel     <= 3'b010;
            cdata_wr <= res_q[NK-1];
          end else if (x_q == XMAX && y_q == XMAX) begin
            state_q <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state_q <= S_FETCH;
            x_q     <= nx_d;
            y_q     <= ny_d;
            tap_q   <= '0;
            inb_q   <= tap_in(nx_d, ny_d, 4'd0);
            if (tap_in(nx_d, ny_d, 4'd0)) iaddr <= tap_addr(nx_d, ny_d, 4'd0);
            for (int k = 0; k < NK; k++) acc_q[k] <= bias_d[k];
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine on a 4x4 image with two kernels: constant and
// position-coded images, saturation, ReLU, rounding, address order and mid-frame reset.
module tb_conv3x3_engine;

  localparam int IMG_W = 4;
  localparam int DW    = 20;
  localparam int FRAC  = 16;
  localparam int NK    = 2;
  localparam int AW    = 4;
  localparam int NPIX  = IMG_W * IMG_W;
  localparam int W     = 3 + AW + DW;

  logic          clk = 1'b0;
  logic          reset, ready, wld, wk, relu_en;
  logic [3:0]    widx;
  logic [DW-1:0] wdata, idata;
  logic          busy, cwr, done;
  logic [AW-1:0] iaddr, caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel, dbg_state;

  int            n_vec  = 0;
  int            n_err  = 0;
  int            wr_cnt = 0;
  bit            mon_en = 1'b0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] img[NPIX];

  conv3x3_engine #(.IMG_W(IMG_W), .DW(DW), .FRAC(FRAC), .NK(NK)) u_dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .wld(wld), .wk(wk), .widx(widx), .wdata(wdata), .relu_en(relu_en), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel), .done(done),
    .dbg_state_o(dbg_state)
  );

  // clock / image memory (one-cycle read latency)
  always #5 clk = ~clk;
  always @(posedge clk) idata <= img[iaddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write must match the head of exp_q; outside writes csel must be idle
  always @(negedge clk) begin
    if (mon_en) begin
      if (cwr === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("unexpected_cwr", cwr, 0);
        else chk($sformatf("write_a%0d_sel%0d", caddr_wr, csel),
                 {csel, caddr_wr, cdata_wr}, exp_q.pop_front());
      end else begin
        chk("csel_idle", csel, 0);
      end
    end
  end

  function automatic logic [DW-1:0] sat_relu(input int v, input bit relu);
    int r;
    r = v;
    if (r > 524287) r = 524287;
    if (r < -524288) r = -524288;
    if (relu && r < 0) r = 0;
    return DW'(r);
  endfunction

  // mode 0: taps 0.5 / -1.0 on constant 1.0 image; 1: tap4 = 1 LSB / bias 1.0 + tap0 1.0
  // on constant 0.5; 2: tap0 / tap8 = 1.0 on image a*0x1000 (pure shifts); 3: all zero
  task automatic push_frame(input int mode, input bit relu);
    int x, y, n, e0, e1;
    for (int a = 0; a < NPIX; a++) begin
      x  = a % IMG_W;
      y  = a / IMG_W;
      n  = ((x == 0 || x == IMG_W-1) ? 2 : 3) * ((y == 0 || y == IMG_W-1) ? 2 : 3);
      e0 = 0;
      e1 = 0;
      case (mode)
        0: begin e0 = n * 32768; e1 = -n * 65536; end
        1: begin e0 = 1; e1 = (x > 0 && y > 0) ? 98304 : 65536; end
        2: begin
          e0 = (x > 0 && y > 0) ? int'(img[a-5]) : 0;
          e1 = (x < IMG_W-1 && y < IMG_W-1) ? int'(img[a+5]) : 0;
        end
        default: ;
      endcase
      exp_q.push_back({3'b001, AW'(a), sat_relu(e0, relu)});
      exp_q.push_back({3'b010, AW'(a), sat_relu(e1, relu)});
    end
  endtask

  task automatic load_w(input logic k, input logic [3:0] idx, input logic [DW-1:0] v);
    @(negedge clk);
    wld = 1'b1; wk = k; widx = idx; wdata = v;
    @(negedge clk);
    wld = 1'b0;
  endtask

  task automatic load_all(input logic k, input logic [DW-1:0] tap, input logic [DW-1:0] bias);
    for (int i = 0; i < 9; i++) load_w(k, 4'(i), tap);
    load_w(k, 4'd9, bias);
    load_w(k, 4'd12, DW'($urandom_range(1, 4095)));
  endtask

  task automatic chk_rst_state(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cwr"}, cwr, 0);
    chk({tag, "_csel"}, csel, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_iaddr"}, iaddr, 0);
    chk({tag, "_caddr"}, caddr_wr, 0);
    chk({tag, "_cdata"}, cdata_wr, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // driver: start a frame, check fetch addresses right after reset, disturb wld/relu_en
  // mid-frame (both must be ignored), and time the frame up to the done pulse
  task automatic run_frame(input bit relu, input bit chk_addr);
    logic [AW-1:0] addr_exp[9];
    int cnt;
    addr_exp = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd4, 4'd5};
    @(negedge clk);
    relu_en = relu;
    ready   = 1'b1;
    cnt     = 0;
    do begin
      @(negedge clk);
      ready = 1'b0;
      cnt++;
      if (cnt == 1) chk("busy_start", busy, 1);
      if (chk_addr && cnt <= 9) chk($sformatf("iaddr_tap%0d", cnt - 1), iaddr, addr_exp[cnt-1]);
      if (cnt == 20) begin
        wld = 1'b1; wk = 1'b0; widx = 4'd4; wdata = DW'($urandom_range(1, 4095));
        relu_en = ~relu;
      end
      if (cnt == 21) wld = 1'b0;
    end while (done !== 1'b1 && cnt < 1000);
    // first negedge after the start edge is cycle 1 of the frame, so done shows one later
    chk("frame_cycles", cnt, NPIX * (10 + NK) + 1);
    chk("busy_in_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    int cnt, base;
    reset = 1'b1; ready = 1'b0; wld = 1'b0; wk = 1'b0; widx = '0; wdata = '0; relu_en = 1'b0;
    for (int a = 0; a < NPIX; a++) img[a] = 20'h10000;
    @(negedge clk);
    @(negedge clk);
    chk_rst_state("rst_init");
    reset  = 1'b0;
    mon_en = 1'b1;

    // load and start in the same cycle: load wins, no frame starts
    @(negedge clk);
    wld = 1'b1; ready = 1'b1; wk = 1'b0; widx = 4'd0; wdata = 20'h08000;
    @(negedge clk);
    chk("load_wins_busy", busy, 0);
    wld = 1'b0; ready = 1'b0;
    @(negedge clk);
    chk("start_deferred_busy", busy, 0);

    load_all(1'b0, 20'h08000, 20'h00000);
    load_all(1'b1, 20'hF0000, 20'h00000);
    push_frame(0, 1'b0);
    run_frame(1'b0, 1'b1);
    push_frame(0, 1'b1);
    run_frame(1'b1, 1'b0);

    for (int a = 0; a < NPIX; a++) img[a] = 20'h08000;
    load_all(1'b0, 20'h00000, 20'h00000);
    load_w(1'b0, 4'd4, 20'h00001);
    load_all(1'b1, 20'h00000, 20'h10000);
    load_w(1'b1, 4'd0, 20'h10000);
    push_frame(1, 1'b0);
    run_frame(1'b0, 1'b0);

    for (int a = 0; a < NPIX; a++) img[a] = DW'(a * 32'h1000);
    load_all(1'b0, 20'h00000, 20'h00000);
    load_w(1'b0, 4'd0, 20'h10000);
    load_all(1'b1, 20'h00000, 20'h00000);
    load_w(1'b1, 4'd8, 20'h10000);
    push_frame(2, 1'b0);
    run_frame(1'b0, 1'b0);

    // reset during the kernel-0 write of pixel 5 (11th write of the frame)
    push_frame(2, 1'b0);
    base = wr_cnt;
    cnt  = 0;
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    while (wr_cnt - base < 11 && cnt < 500) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    reset = 1'b1;
    @(negedge clk);
    chk_rst_state("rst_mid");
    chk("writes_before_reset", wr_cnt - base, 11);
    exp_q.delete();
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("idle_after_reset_busy", busy, 0);

    // weights were cleared: an unloaded frame yields zeros, then reload and rerun
    push_frame(3, 1'b0);
    run_frame(1'b0, 1'b1);
    load_w(1'b0, 4'd0, 20'h10000);
    load_w(1'b1, 4'd8, 20'h10000);
    push_frame(2, 1'b0);
    run_frame(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
